// File: rtl/tx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tx_pkg
//  Brief    : Shared definitions for the hop scheduler and bit transmitter:
//             scheduler state encoding, time-of-day field widths, hop length
//             defaults and the effective hop length rule.
//  Revision : 1.0  initial release
// ============================================================================
package tx_pkg;

    // Time-of-day field widths: hop index and tick within the hop
    localparam int c_TOD_H_W = 21;
    localparam int c_TOD_L_W = 11;

    // Default hop length, minimum legal hop length and ARM guard length.
    // The minimum covers a bit start at tick 512 plus 33 bits of 20 ticks.
    localparam logic [c_TOD_L_W-1:0] c_HOP_LEN_DEF = 11'd1280;
    localparam logic [c_TOD_L_W-1:0] c_HOP_LEN_MIN = 11'd1200;
    localparam int unsigned          c_GUARD       = 16;

    // Scheduler states, explicitly encoded so other blocks can decode them
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Hop length actually used for a frame: zero selects the default, short
    // values are stretched to the minimum, anything else is taken as given.
    function automatic logic [c_TOD_L_W-1:0] eff_hop_len(
        input logic [c_TOD_L_W-1:0] cfg_len,
        input logic [c_TOD_L_W-1:0] def_len,
        input logic [c_TOD_L_W-1:0] min_len
    );
        logic [c_TOD_L_W-1:0] v_len;
        if (cfg_len == '0) begin
            v_len = def_len;
        end else if (cfg_len < min_len) begin
            v_len = min_len;
        end else begin
            v_len = cfg_len;
        end
        return v_len;
    endfunction

endpackage : tx_pkg
`default_nettype wire

// File: rtl/tx_tod_cnt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tx_tod_cnt
//  Brief    : Time-of-day counter. tod_l counts ticks within a hop and wraps
//             at len-1, bumping tod_h. last_tick flags the final tick of the
//             current hop so the scheduler can detect the frame end.
//  Revision : 1.0  initial release
// ============================================================================
module tx_tod_cnt
    import tx_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [c_TOD_L_W-1:0] len,
    output logic [c_TOD_H_W-1:0] tod_h,
    output logic [c_TOD_L_W-1:0] tod_l,
    output logic                 last_tick
);

    logic [c_TOD_H_W-1:0] r_tod_h;
    logic [c_TOD_L_W-1:0] r_tod_l;

    // Final tick of the current hop
    assign last_tick = (r_tod_l == (len - c_TOD_L_W'(1)));

    // Tick/hop counter: clear dominates, otherwise advance when enabled
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_tod_h <= '0;
            r_tod_l <= '0;
        end else if (enable) begin
            if (last_tick) begin
                r_tod_l <= '0;
                r_tod_h <= r_tod_h + c_TOD_H_W'(1);
            end else begin
                r_tod_l <= r_tod_l + c_TOD_L_W'(1);
            end
        end
    end

    assign tod_h = r_tod_h;
    assign tod_l = r_tod_l;

endmodule : tx_tod_cnt
`default_nettype wire

// File: rtl/tx_hop_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tx_hop_sched
//  Brief    : Frequency-hop frame scheduler. Accepts a frame start, checks
//             and latches the hop count and hop length, waits a guard period,
//             then drives the hop index / tick counters for the transmitter
//             and reports completion, abort and configuration errors with
//             single-cycle registered pulses.
//  Revision : 1.0  initial release
// ============================================================================
module tx_hop_sched
    import tx_pkg::*;
#(
    parameter logic [10:0] HOP_LEN_DEF = c_HOP_LEN_DEF,
    parameter logic [10:0] HOP_LEN_MIN = c_HOP_LEN_MIN,
    parameter int unsigned GUARD       = c_GUARD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] cfg_fh_num,
    input  logic [10:0] cfg_hop_len,
    output logic [20:0] tod_h,
    output logic [10:0] tod_l,
    output logic [31:0] fh_num,
    output logic        busy,
    output logic        hop_strobe,
    output logic        done,
    output logic        aborted,
    output logic        err_cfg
);

    // Guard counter sized for GUARD values; counts 0 .. GUARD-1
    localparam int             c_GW         = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [c_GW-1:0] c_GUARD_LAST = c_GW'(GUARD - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_GW-1:0]       r_guard;
    logic [c_GW-1:0]       w_guard_nxt;

    // Frame configuration captured at start acceptance
    logic [31:0]           r_fh_lat;
    logic [c_TOD_L_W-1:0]  r_len_lat;
    logic                  w_latch;

    // Registered outputs and their next values
    logic [31:0]           r_fh_num;
    logic                  r_busy;
    logic                  r_hop_strobe;
    logic                  r_done;
    logic                  r_aborted;
    logic                  r_err_cfg;
    logic                  w_strobe_nxt;
    logic                  w_done_nxt;
    logic                  w_aborted_nxt;
    logic                  w_err_nxt;

    // Counter control and status
    logic                  w_cnt_en;
    logic                  w_cnt_clr;
    logic                  w_last_tick;
    logic                  w_last_hop;
    logic                  w_cfg_bad;
    logic [c_TOD_H_W-1:0]  w_tod_h;
    logic [c_TOD_L_W-1:0]  w_tod_l;

    // A hop count of zero or one that does not fit the hop index is rejected
    assign w_cfg_bad  = (cfg_fh_num == 32'd0) || (cfg_fh_num[31:21] != 11'd0);

    // Current hop is the last one of the frame
    assign w_last_hop = (w_tod_h == (r_fh_lat[c_TOD_H_W-1:0] - c_TOD_H_W'(1)));

    // Counter runs only while staying in RUN; any other path holds it at zero
    assign w_cnt_clr  = !w_cnt_en;

    tx_tod_cnt u_tod_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_cnt_clr),
        .enable    (w_cnt_en),
        .len       (r_len_lat),
        .tod_h     (w_tod_h),
        .tod_l     (w_tod_l),
        .last_tick (w_last_tick)
    );

    // Next-state and pulse decode; abort has precedence over every other event
    always_comb begin
        w_state_nxt   = r_state;
        w_guard_nxt   = r_guard;
        w_latch       = 1'b0;
        w_cnt_en      = 1'b0;
        w_strobe_nxt  = 1'b0;
        w_done_nxt    = 1'b0;
        w_aborted_nxt = 1'b0;
        w_err_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // start together with abort is treated as no request at all
                if (start && !abort) begin
                    if (w_cfg_bad) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_latch     = 1'b1;
                        w_guard_nxt = '0;
                        w_state_nxt = ST_ARM;
                    end
                end
            end

            ST_ARM: begin
                if (abort) begin
                    w_aborted_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (r_guard == c_GUARD_LAST) begin
                    // First tick of hop 0 is visible on RUN entry
                    w_strobe_nxt = 1'b1;
                    w_state_nxt  = ST_RUN;
                end else begin
                    w_guard_nxt = r_guard + c_GW'(1);
                end
            end

            ST_RUN: begin
                if (abort) begin
                    w_aborted_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (w_last_tick && w_last_hop) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_en     = 1'b1;
                    w_strobe_nxt = w_last_tick;
                end
            end

            ST_DONE: begin
                w_aborted_nxt = abort;
                w_state_nxt   = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and guard counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_guard <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_guard <= w_guard_nxt;
        end
    end

    // Configuration latch; later cfg_* changes cannot disturb an active frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fh_lat  <= '0;
            r_len_lat <= HOP_LEN_DEF;
        end else if (w_latch) begin
            r_fh_lat  <= cfg_fh_num;
            r_len_lat <= eff_hop_len(cfg_hop_len, HOP_LEN_DEF, HOP_LEN_MIN);
        end
    end

    // Output registers, all derived from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fh_num     <= '0;
            r_busy       <= 1'b0;
            r_hop_strobe <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_err_cfg    <= 1'b0;
        end else begin
            r_fh_num     <= (w_state_nxt == ST_RUN) ? r_fh_lat : 32'd0;
            r_busy       <= (w_state_nxt == ST_ARM) || (w_state_nxt == ST_RUN);
            r_hop_strobe <= w_strobe_nxt;
            r_done       <= w_done_nxt;
            r_aborted    <= w_aborted_nxt;
            r_err_cfg    <= w_err_nxt;
        end
    end

    assign tod_h      = w_tod_h;
    assign tod_l      = w_tod_l;
    assign fh_num     = r_fh_num;
    assign busy       = r_busy;
    assign hop_strobe = r_hop_strobe;
    assign done       = r_done;
    assign aborted    = r_aborted;
    assign err_cfg    = r_err_cfg;

endmodule : tx_hop_sched
`default_nettype wire

// File: tb/tb_tx_hop_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_tx_hop_sched
//  Brief    : Self-checking bench for tx_hop_sched. Expected outputs come from
//             a frame timeline model: ARM for 16 cycles, then N*L run cycles
//             where tick t maps to hop t/L and tick t%L, then one DONE cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tx_hop_sched;

    localparam int c_GUARD_M   = 16;
    localparam int c_LEN_DEF_M = 1280;
    localparam int c_LEN_MIN_M = 1200;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] cfg_fh_num;
    logic [10:0] cfg_hop_len;
    logic [20:0] tod_h;
    logic [10:0] tod_l;
    logic [31:0] fh_num;
    logic        busy;
    logic        hop_strobe;
    logic        done;
    logic        aborted;
    logic        err_cfg;

    int n_checks = 0;
    int n_errors = 0;

    tx_hop_sched dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_fh_num  (cfg_fh_num),
        .cfg_hop_len (cfg_hop_len),
        .tod_h       (tod_h),
        .tod_l       (tod_l),
        .fh_num      (fh_num),
        .busy        (busy),
        .hop_strobe  (hop_strobe),
        .done        (done),
        .aborted     (aborted),
        .err_cfg     (err_cfg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input int eh, input int el, input int efh,
                        input logic eb, input logic es, input logic ed,
                        input logic ea, input logic ee);
        chk({tag, " tod_h"},      32'(tod_h),      32'(eh));
        chk({tag, " tod_l"},      32'(tod_l),      32'(el));
        chk({tag, " fh_num"},     fh_num,          32'(efh));
        chk({tag, " busy"},       32'(busy),       32'(eb));
        chk({tag, " hop_strobe"}, 32'(hop_strobe), 32'(es));
        chk({tag, " done"},       32'(done),       32'(ed));
        chk({tag, " aborted"},    32'(aborted),    32'(ea));
        chk({tag, " err_cfg"},    32'(err_cfg),    32'(ee));
    endtask

    task automatic idle_chk(input string tag);
        outs(tag, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic int model_len(input logic [10:0] cl);
        if (cl == 11'd0)                  return c_LEN_DEF_M;
        else if (int'(cl) < c_LEN_MIN_M)  return c_LEN_MIN_M;
        else                              return int'(cl);
    endfunction

    // Run one frame. stop_kind: 0 none, 1 abort, 2 reset, applied while the
    // outputs show hop stop_h / tick stop_l. restart_h >= 0 issues a second
    // start while hop restart_h tick 5 is shown.
    task automatic frame(input string tag, input int n, input logic [10:0] cl,
                         input int stop_kind, input int stop_h, input int stop_l,
                         input int restart_h);
        int   len_m;
        int   run_end;
        int   t;
        int   eh;
        int   el;
        int   efh;
        logic eb;
        logic es;
        logic ed;
        int   strobes;
        int   dones;
        bit   ended;

        len_m   = model_len(cl);
        run_end = c_GUARD_M + n * len_m;
        strobes = 0;
        dones   = 0;
        ended   = 1'b0;

        cfg_fh_num  = 32'(n);
        cfg_hop_len = cl;
        start       = 1'b1;
        step();
        start = 1'b0;

        for (int k = 1; (k <= run_end + 1) && !ended; k++) begin
            if (k <= c_GUARD_M) begin
                eh = 0; el = 0; efh = 0; eb = 1'b1; es = 1'b0; ed = 1'b0;
            end else if (k <= run_end) begin
                t  = k - c_GUARD_M - 1;
                eh = t / len_m; el = t % len_m; efh = n;
                eb = 1'b1; es = (el == 0); ed = 1'b0;
            end else begin
                eh = 0; el = 0; efh = 0; eb = 1'b0; es = 1'b0; ed = 1'b1;
            end
            outs(tag, eh, el, efh, eb, es, ed, 1'b0, 1'b0);
            strobes += int'(hop_strobe);
            dones   += int'(done);

            // Configuration inputs wander freely during the frame
            cfg_fh_num  = $urandom;
            cfg_hop_len = 11'($urandom);

            if (stop_kind != 0 && k > c_GUARD_M && k <= run_end &&
                eh == stop_h && el == stop_l) begin
                if (stop_kind == 1) abort = 1'b1;
                else                rst   = 1'b1;
                step();
                abort = 1'b0;
                rst   = 1'b0;
                outs({tag, " stop"}, 0, 0, 0, 1'b0, 1'b0, 1'b0, (stop_kind == 1), 1'b0);
                ended = 1'b1;
            end else begin
                if (restart_h >= 0 && k > c_GUARD_M && k <= run_end &&
                    eh == restart_h && el == 5) begin
                    cfg_fh_num  = 32'd1;
                    cfg_hop_len = 11'd1200;
                    start       = 1'b1;
                end
                step();
                start = 1'b0;
            end
        end

        if (!ended) begin
            idle_chk({tag, " after_done"});
            chk({tag, " strobe_count"}, 32'(strobes), 32'(n));
            chk({tag, " done_count"},   32'(dones),   32'd1);
        end else begin
            chk({tag, " done_count"},   32'(dones),   32'd0);
        end
        step();
        idle_chk({tag, " quiet"});
    endtask

    task automatic bad_start(input string tag, input logic [31:0] n);
        cfg_fh_num  = n;
        cfg_hop_len = 11'($urandom);
        start       = 1'b1;
        step();
        start = 1'b0;
        outs(tag, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        idle_chk({tag, " after"});
    endtask

    initial begin
        int          n;
        int          len_m;
        int          kind;
        logic [10:0] cl;

        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        cfg_fh_num  = 32'd0;
        cfg_hop_len = 11'd0;
        step();
        step();
        idle_chk("reset");

        // Reset wins over a valid start
        cfg_fh_num = 32'd2;
        start      = 1'b1;
        step();
        start = 1'b0;
        idle_chk("rst_over_start");
        rst = 1'b0;
        step();
        idle_chk("post_reset");

        // Nominal 3-hop frame at the default length
        frame("nominal", 3, 11'd1280, 0, 0, 0, -1);

        // Hop length selection
        frame("len_zero", 1, 11'd0,    0, 0, 0, -1);
        frame("len_100",  1, 11'd100,  0, 0, 0, -1);
        frame("len_1500", 1, 11'd1500, 0, 0, 0, -1);

        // Rejected configurations
        bad_start("err_zero", 32'd0);
        bad_start("err_wide", 32'h0020_0000);
        bad_start("err_rand", $urandom | 32'h0020_0000);

        // start and abort together in IDLE do nothing
        cfg_fh_num  = 32'd2;
        cfg_hop_len = 11'd1300;
        start       = 1'b1;
        abort       = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        idle_chk("start_abort_idle");
        step();
        idle_chk("start_abort_idle2");

        // Abort during the guard period
        cfg_fh_num = 32'd2;
        start      = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        outs("arm", 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        outs("arm_abort", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        idle_chk("arm_abort_quiet");

        // Abort mid-frame, abort on the final tick with a mid-run restart
        frame("abort_mid",  4, 11'd1280, 1, 1, 700, -1);
        frame("abort_last", 2, 11'd1200, 1, 1, 1199, 0);

        // Reset mid-frame, then a normal frame
        frame("rst_mid",   3, 11'd1200, 2, 2, 100, -1);
        frame("after_rst", 1, 11'd1250, 0, 0, 0, -1);

        // Randomized frames
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 3);
            case ($urandom_range(0, 2))
                0:       cl = 11'd0;
                1:       cl = 11'($urandom_range(1, 1199));
                default: cl = 11'($urandom_range(1200, 1600));
            endcase
            len_m = model_len(cl);
            kind  = $urandom_range(0, 2);
            frame("random", n, cl, kind, $urandom_range(0, n - 1),
                  $urandom_range(0, len_m - 1), (r == 1) ? 0 : -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_tx_hop_sched
`default_nettype wire

// File: doc/tx_hop_sched.md
TX_HOP_SCHED -- requirements
Module: tx_hop_sched

Interface
REQ-001 SHALL have parameter HOP_LEN_DEF, default 11'd1280, meaning ticks per hop used when cfg_hop_len is 0.
REQ-002 SHALL have parameter HOP_LEN_MIN, default 11'd1200, meaning the minimum legal hop length (covers bit start at tick 512 plus 33 x 20-tick bits).
REQ-003 SHALL have parameter GUARD, default 16, meaning the number of ARM-state cycles between start acceptance and the first hop.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic rises on it.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: single-cycle frame start request.
REQ-007 SHALL have port abort, input, 1 bit: single-cycle frame abort request.
REQ-008 SHALL have port cfg_fh_num, input, 32 bits: number of hops in the frame, sampled on start acceptance.
REQ-009 SHALL have port cfg_hop_len, input, 11 bits: ticks per hop, sampled on start acceptance.
REQ-010 SHALL have port tod_h, output, 21 bits: hop index, driven to the bit transmitter and to the data RAM address.
REQ-011 SHALL have port tod_l, output, 11 bits: tick within the hop.
REQ-012 SHALL have port fh_num, output, 32 bits: active hop count; 0 whenever not RUN, so the transmitter stays idle.
REQ-013 SHALL have port busy, output, 1 bit: high in ARM and RUN.
REQ-014 SHALL have port hop_strobe, output, 1 bit: one-cycle pulse when tod_l==0 in RUN.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse on normal frame completion.
REQ-016 SHALL have port aborted, output, 1 bit: one-cycle pulse on abort.
REQ-017 SHALL have port err_cfg, output, 1 bit: one-cycle pulse on a rejected start.

Function
REQ-018 SHALL implement states IDLE, ARM, RUN and DONE.
REQ-019 IDLE SHALL hold tod_h=0, tod_l=0, fh_num=0 and busy=0.
REQ-020 In IDLE, a start with cfg_fh_num==0 or cfg_fh_num[31:21]!=0 SHALL pulse err_cfg the next cycle and remain in IDLE.
REQ-021 In IDLE, any other start SHALL latch cfg_fh_num and the effective hop length, then enter ARM.
REQ-022 Effective hop length SHALL be HOP_LEN_DEF if cfg_hop_len==0, HOP_LEN_MIN if cfg_hop_len<HOP_LEN_MIN, and cfg_hop_len otherwise.
REQ-023 ARM SHALL count GUARD cycles with fh_num=0 and then enter RUN with tod_h=0 and tod_l=0.
REQ-024 On RUN entry, fh_num SHALL show the latched value.
REQ-025 RUN SHALL advance tod_l by 1 per clk and wrap from len-1 to 0, incrementing tod_h on the wrap.
REQ-026 RUN SHALL keep tod_h[20:0] < fh_num; no wrap of tod_h is reachable.
REQ-027 When tod_h==fh_num-1 and tod_l==len-1, the next state SHALL be DONE.
REQ-028 DONE SHALL last one cycle with done=1, fh_num=0, tod_h=0 and tod_l=0, then go to IDLE.
REQ-029 abort in ARM, RUN or DONE SHALL force IDLE on the next cycle with aborted=1 and done suppressed.
REQ-030 abort SHALL win over the RUN-to-DONE transition in the same cycle.
REQ-031 start while busy SHALL be ignored, with no err_cfg.
REQ-032 start and abort together in IDLE SHALL cause no state change and no pulses.
REQ-033 A changing cfg_* input SHALL have no effect on an active frame.
REQ-034 All outputs SHALL be registered; every output changes one clk after the causing input or state event.

Reset
REQ-035 rst=1 SHALL, on the next clk, place the block in IDLE with tod_h=0, tod_l=0, fh_num=0 and busy, hop_strobe, done, aborted, err_cfg all 0.
REQ-036 rst asserted mid-frame SHALL terminate the frame silently, with no done and no aborted pulse.
REQ-037 rst SHALL take priority over start and abort.

Structure
REQ-038 Shared package tx_pkg SHALL hold the state encoding and the HOP_LEN_DEF, HOP_LEN_MIN and GUARD defaults, for reuse by the transmitter and the testbench.
REQ-039 One sub-module tx_tod_cnt SHALL implement the tod_l/tod_h counter, with inputs clear, enable and len, and a last-tick flag output.
REQ-040 tx_hop_sched SHALL instantiate tx_tod_cnt once and contain the FSM, configuration latch and pulse generation.

Verification
REQ-041 Bench SHALL cover: cfg_fh_num=3, cfg_hop_len=1280, start -> after 16 ARM cycles, 3x1280 RUN cycles, tod_h sequence 0,1,2, three hop_strobe pulses, one done, fh_num back to 0.
REQ-042 Bench SHALL cover: cfg_hop_len=0 -> period 1280; cfg_hop_len=100 -> period 1200; cfg_hop_len=1500 -> period 1500.
REQ-043 Bench SHALL cover: cfg_fh_num=0 and cfg_fh_num=32'h0020_0000 each with start -> err_cfg pulse, busy stays 0.
REQ-044 Bench SHALL cover: abort at tod_h=1, tod_l=700 of a 4-hop frame -> IDLE next cycle, aborted=1, done never asserted, fh_num=0.
REQ-045 Bench SHALL cover: abort coincident with the final tick -> aborted=1, done=0; a second start mid-RUN is ignored and the frame length is unchanged.
REQ-046 Bench SHALL cover: rst at tod_h=2 -> all outputs 0 next cycle, no pulses; a subsequent start runs normally.
